// File: rtl/zcu216_clk_pkg.sv
// zcu216_clk_pkg: shared FSM states and constants for the ADC clock/reset sequencer
package zcu216_clk_pkg;
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2,
    LOST      = 2'd3
  } state_e;
  localparam int CNT_W = 16;
  localparam int STABLE_CYCLES_DEF = 1024;
endpackage

// File: rtl/zcu216_bit_sync.sv
// zcu216_bit_sync: multi-flop synchroniser for a single asynchronous level
module zcu216_bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  always_comb sync_d = {sync_q[STAGES-2:0], d};
  always_ff @(posedge clk or posedge rst)
    if (rst) sync_q <= '0;
    else sync_q <= sync_d;
  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/zcu216_clk_reset_seq.sv
// zcu216_clk_reset_seq: holds adc_clk-domain logic in reset until the MMCM lock has been stable
module zcu216_clk_reset_seq
  import zcu216_clk_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             adc_clk,
  input  logic             rst,
  input  logic             mmcm_locked,
  input  logic             sw_rst,
  input  logic             cnt_clr,
  output logic             adc_rst,
  output logic             clk_ready,
  output logic [CNT_W-1:0] lock_loss_cnt,
  output logic [1:0]       state_o
);
  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYCLES - 1);
  logic locked_s;
  state_e state_q, state_d;
  logic [CNT_W-1:0] stab_q, stab_d, loss_q, loss_d;
  logic adc_rst_q, adc_rst_d, clk_ready_q, clk_ready_d, enter_lost;
  zcu216_bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(adc_clk),
    .rst(rst),
    .d  (mmcm_locked),
    .q  (locked_s)
  );
  // A lock drop in RUN wins over a coincident software reset so the loss is counted
  always_comb begin
    state_d = state_q;
    stab_d = stab_q;
    case (state_q)
      WAIT_LOCK: begin
        state_d = (locked_s && !sw_rst) ? STABLE : WAIT_LOCK;
        stab_d = '0;
      end
      STABLE: begin
        state_d = (sw_rst || !locked_s) ? WAIT_LOCK : (stab_q == STAB_LAST) ? RUN : STABLE;
        stab_d = stab_q + 1'b1;
      end
      RUN: state_d = !locked_s ? LOST : sw_rst ? WAIT_LOCK : RUN;
      default: state_d = WAIT_LOCK;
    endcase
    enter_lost = (state_q == RUN) && !locked_s;
    loss_d = cnt_clr ? CNT_W'(enter_lost) : (enter_lost && ~&loss_q) ? loss_q + 1'b1 : loss_q;
    adc_rst_d = state_d != RUN;
    clk_ready_d = (state_q == RUN) && (state_d == RUN);
  end
  always_ff @(posedge adc_clk or posedge rst)
    if (rst) begin
      state_q <= WAIT_LOCK;
      stab_q <= '0;
      loss_q <= '0;
      adc_rst_q <= 1'b1;
      clk_ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stab_q <= stab_d;
      loss_q <= loss_d;
      adc_rst_q <= adc_rst_d;
      clk_ready_q <= clk_ready_d;
    end
  assign adc_rst = adc_rst_q;
  assign clk_ready = clk_ready_q;
  assign lock_loss_cnt = loss_q;
  assign state_o = state_q;
endmodule

// File: tb/tb_zcu216_clk_reset_seq.sv
// tb_zcu216_clk_reset_seq: directed and random stimulus against a streak-counting reference model
module tb_zcu216_clk_reset_seq;
  localparam int SC = 16;
  localparam int SS = 2;
  logic adc_clk = 1'b0;
  logic rst = 1'b0;
  logic mmcm_locked = 1'b0;
  logic sw_rst = 1'b0;
  logic cnt_clr = 1'b0;
  logic adc_rst, clk_ready;
  logic [15:0] lock_loss_cnt;
  logic [1:0] state_o;
  int total = 0;
  int bad = 0;
  logic [SS-1:0] hist;
  int streak, run_len, n;
  bit lost;
  logic [15:0] cnt;

  zcu216_clk_reset_seq #(.STABLE_CYCLES(SC), .SYNC_STAGES(SS)) dut (
    .adc_clk      (adc_clk),
    .rst          (rst),
    .mmcm_locked  (mmcm_locked),
    .sw_rst       (sw_rst),
    .cnt_clr      (cnt_clr),
    .adc_rst      (adc_rst),
    .clk_ready    (clk_ready),
    .lock_loss_cnt(lock_loss_cnt),
    .state_o      (state_o)
  );

  always #5 adc_clk = ~adc_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist = '0;
    streak = 0;
    run_len = 0;
    lost = 0;
    cnt = 16'd0;
  endtask

  // streak = locked cycles seen since the last time the lock was first observed; release after SC+1
  task automatic step();
    bit ls, enter;
    @(posedge adc_clk);
    #1;
    ls = hist[SS-1];
    hist = {hist[SS-2:0], mmcm_locked};
    enter = 0;
    if (lost) begin
      lost = 0;
      streak = 0;
    end else if (run_len > 0) begin
      if (!ls) begin
        run_len = 0;
        lost = 1;
        enter = 1;
      end else if (sw_rst) run_len = 0;
      else run_len++;
    end else if (sw_rst || !ls) streak = 0;
    else if (streak == SC) begin
      streak = 0;
      run_len = 1;
    end else streak++;
    cnt = cnt_clr ? {15'd0, enter} : (enter && cnt != 16'hFFFF) ? cnt + 16'd1 : cnt;
    chk("adc_rst", {31'd0, adc_rst}, {31'd0, run_len == 0});
    chk("clk_ready", {31'd0, clk_ready}, {31'd0, run_len >= 2});
    chk("state_o", {30'd0, state_o}, lost ? 32'd3 : run_len > 0 ? 32'd2 : streak > 0 ? 32'd1 : 32'd0);
    chk("loss_cnt", {16'd0, lock_loss_cnt}, {16'd0, cnt});
  endtask

  task automatic wait_release(output int steps);
    steps = 0;
    while (adc_rst && steps < 200) begin
      step();
      steps++;
    end
    if (adc_rst) chk("release_timeout", 32'd1, 32'd0);
  endtask

  task automatic drop_once();
    mmcm_locked = 1'b0;
    step();
    mmcm_locked = 1'b1;
    repeat (2) step();
    chk("drop_lost", {30'd0, state_o}, 32'd3);
    wait_release(n);
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b1;
    #3;
    chk("rst_adc_rst", {31'd0, adc_rst}, 32'd1);
    chk("rst_clk_ready", {31'd0, clk_ready}, 32'd0);
    chk("rst_cnt", {16'd0, lock_loss_cnt}, 32'd0);
    chk("rst_state", {30'd0, state_o}, 32'd0);
    repeat (3) @(negedge adc_clk);
    rst = 1'b0;
    repeat (9) step();
    mmcm_locked = 1'b1;
    wait_release(n);
    chk("release_latency", n, SS + SC + 1);
    step();
    chk("ready_after", {31'd0, clk_ready}, 32'd1);
    sw_rst = 1'b1;
    step();
    sw_rst = 1'b0;
    chk("sw_rst_assert", {31'd0, adc_rst}, 32'd1);
    wait_release(n);
    chk("sw_relock", n, SC + 1);
    sw_rst = 1'b1;
    step();
    sw_rst = 1'b0;
    repeat (8) step();
    mmcm_locked = 1'b0;
    repeat (3) step();
    mmcm_locked = 1'b1;
    wait_release(n);
    chk("glitch_relock", n, SS + SC + 1);
    repeat (3) drop_once();
    chk("three_losses", {16'd0, lock_loss_cnt}, 32'd3);
    mmcm_locked = 1'b0;
    step();
    mmcm_locked = 1'b1;
    step();
    sw_rst = 1'b1;
    step();
    sw_rst = 1'b0;
    chk("sw_drop_lost", {30'd0, state_o}, 32'd3);
    chk("sw_drop_cnt", {16'd0, lock_loss_cnt}, 32'd4);
    wait_release(n);
    force dut.loss_q = 16'hFFFE;
    #1 release dut.loss_q;
    cnt = 16'hFFFE;
    repeat (3) drop_once();
    chk("saturate", {16'd0, lock_loss_cnt}, 32'h0000FFFF);
    mmcm_locked = 1'b0;
    step();
    mmcm_locked = 1'b1;
    step();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr_with_loss", {16'd0, lock_loss_cnt}, 32'd1);
    wait_release(n);
    for (int i = 0; i < 3000; i++) begin
      mmcm_locked = $urandom_range(0, 39) != 0;
      sw_rst = $urandom_range(0, 63) == 0;
      cnt_clr = $urandom_range(0, 127) == 0;
      step();
    end
    sw_rst = 1'b0;
    cnt_clr = 1'b0;
    mmcm_locked = 1'b1;
    wait_release(n);
    drop_once();
    step();
    #2 rst = 1'b1;
    #1;
    chk("async_adc_rst", {31'd0, adc_rst}, 32'd1);
    chk("async_clk_ready", {31'd0, clk_ready}, 32'd0);
    chk("async_cnt", {16'd0, lock_loss_cnt}, 32'd0);
    chk("async_state", {30'd0, state_o}, 32'd0);
    model_reset();
    @(negedge adc_clk);
    rst = 1'b0;
    wait_release(n);
    chk("post_rst_latency", n, SS + SC + 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
